// File: rtl/prince_pkg.sv
// Shared definitions for the masked PRINCE S-layer: widths, controller states
// and the PRINCE S-box table (the table is used only by reference models).
package prince_pkg;

    localparam int NIB_W          = 4;
    localparam int PRINCE_STATE_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Entry k of the S-box sits at bits [4k+3:4k].
    localparam logic [63:0] PRINCE_SBOX = 64'h4D5E_0876_19CA_23FB;

    function automatic logic [3:0] prince_sbox(input logic [3:0] x);
        return PRINCE_SBOX[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/prince_nibble_collect.sv
// Delays each issued nibble index by the S-box latency and writes the returned
// S-box output shares into the matching nibble of the two result registers.
module prince_nibble_collect
    import prince_pkg::*;
#(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 1,
    localparam int CNT_W   = $clog2(NIBBLES),
    localparam int STATE_W = NIBBLES * NIB_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_v_i,
    input  logic [CNT_W-1:0]   issue_idx_i,
    input  logic [NIB_W-1:0]   sbox_out1_i,
    input  logic [NIB_W-1:0]   sbox_out2_i,
    output logic [STATE_W-1:0] state_out1_o,
    output logic [STATE_W-1:0] state_out2_o
);

    logic             v_q    [SBOX_LAT];
    logic [CNT_W-1:0] idx_q  [SBOX_LAT];
    logic [NIB_W-1:0] out1_q [NIBBLES];
    logic [NIB_W-1:0] out2_q [NIBBLES];
    logic             cap_v;
    logic [CNT_W-1:0] cap_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                v_q[i]   <= 1'b0;
                idx_q[i] <= '0;
            end
        end else begin
            v_q[0]   <= issue_v_i;
            idx_q[0] <= issue_idx_i;
            for (int i = 1; i < SBOX_LAT; i++) begin
                v_q[i]   <= v_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign cap_v   = v_q[SBOX_LAT-1];
    assign cap_idx = idx_q[SBOX_LAT-1];

    // Shares are written independently; they are never combined here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NIBBLES; i++) begin
                out1_q[i] <= '0;
                out2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cap_v && (cap_idx == CNT_W'(i))) begin
                    out1_q[i] <= sbox_out1_i;
                    out2_q[i] <= sbox_out2_i;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_pack
        assign state_out1_o[gi*NIB_W +: NIB_W] = out1_q[gi];
        assign state_out2_o[gi*NIB_W +: NIB_W] = out2_q[gi];
    end

endmodule

// File: rtl/prince_slayer_serial_ctrl.sv
// Nibble-serial controller for the 2-share PRINCE S-layer: feeds one nibble pair
// per cycle to an external registered S-box and reassembles the 64-bit result.
module prince_slayer_serial_ctrl
    import prince_pkg::*;
#(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 1,
    localparam int CNT_W   = $clog2(NIBBLES),
    localparam int STATE_W = NIBBLES * NIB_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in_share1,
    input  logic [STATE_W-1:0] state_in_share2,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_out_share1,
    output logic [STATE_W-1:0] state_out_share2,
    output logic [NIB_W-1:0]   sbox_in_share1,
    output logic [NIB_W-1:0]   sbox_in_share2,
    input  logic [NIB_W-1:0]   sbox_out_share1,
    input  logic [NIB_W-1:0]   sbox_out_share2,
    output logic               prng_en
);

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [STATE_W-1:0] sh1_q;
    logic [STATE_W-1:0] sh2_q;
    logic [NIB_W-1:0]   sbox_in1_q;
    logic [NIB_W-1:0]   sbox_in2_q;
    logic               busy_q;
    logic               done_q;
    logic               prng_en_q;

    // The shift registers hold the not-yet-issued nibbles; the S-box ports are
    // fed only from registers so input shares never reach the S-box directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            sbox_in1_q <= '0;
            sbox_in2_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prng_en_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ISSUE;
                        cnt_q      <= '0;
                        sh1_q      <= state_in_share1 >> NIB_W;
                        sh2_q      <= state_in_share2 >> NIB_W;
                        sbox_in1_q <= state_in_share1[NIB_W-1:0];
                        sbox_in2_q <= state_in_share2[NIB_W-1:0];
                        prng_en_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // busy rises one cycle after accept and stays up through DRAIN.
                    busy_q <= 1'b1;
                    if (cnt_q == LAST_NIB) begin
                        state_q    <= DRAIN;
                        sbox_in1_q <= '0;
                        sbox_in2_q <= '0;
                        prng_en_q  <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                        sbox_in1_q <= sh1_q[NIB_W-1:0];
                        sbox_in2_q <= sh2_q[NIB_W-1:0];
                        sh1_q      <= sh1_q >> NIB_W;
                        sh2_q      <= sh2_q >> NIB_W;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    prince_nibble_collect #(
        .NIBBLES  (NIBBLES),
        .SBOX_LAT (SBOX_LAT)
    ) u_collect (
        .clk          (clk),
        .rst          (rst),
        .issue_v_i    (prng_en_q),
        .issue_idx_i  (cnt_q),
        .sbox_out1_i  (sbox_out_share1),
        .sbox_out2_i  (sbox_out_share2),
        .state_out1_o (state_out_share1),
        .state_out2_o (state_out_share2)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign prng_en        = prng_en_q;
    assign sbox_in_share1 = sbox_in1_q;
    assign sbox_in_share2 = sbox_in2_q;

endmodule

// File: tb/tb_prince_slayer_serial_ctrl.sv
// Directed bench for the nibble-serial PRINCE S-layer controller with a
// registered 2-share S-box model fed by a free-running random mask source.
module tb_prince_slayer_serial_ctrl;
    import prince_pkg::*;

    localparam logic [63:0] PLAIN     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PLAIN_RES = 64'hBF32_AC91_6780_E5D4;
    localparam logic [63:0] ZERO_RES  = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES_RES  = 64'h4444_4444_4444_4444;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] in1 = '0;
    logic [63:0] in2 = '0;
    logic        busy, done, prng_en;
    logic [63:0] out1, out2;
    logic [3:0]  sbi1, sbi2;
    logic [3:0]  sbo1, sbo2;
    logic [3:0]  prng_bits;

    int checks = 0;
    int errors = 0;
    int prng_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int idle_bad = 0;

    always #5 clk = ~clk;

    prince_slayer_serial_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .state_in_share1  (in1),
        .state_in_share2  (in2),
        .busy             (busy),
        .done             (done),
        .state_out_share1 (out1),
        .state_out_share2 (out2),
        .sbox_in_share1   (sbi1),
        .sbox_in_share2   (sbi2),
        .sbox_out_share1  (sbo1),
        .sbox_out_share2  (sbo2),
        .prng_en          (prng_en)
    );

    // Masked S-box model: one register stage, output share 2 is the fresh mask.
    always @(negedge clk) prng_bits <= 4'($urandom);
    always @(posedge clk) begin
        sbo1 <= prince_sbox(sbi1 ^ sbi2) ^ prng_bits;
        sbo2 <= prng_bits;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prng_en) prng_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (!prng_en && (sbi1 != 4'h0 || sbi2 != 4'h0)) idle_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at #1 after an edge with the DUT idle; returns in the done cycle.
    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2,
                          input int pa, input int pb,
                          output int lat, output logic [63:0] early);
        start = 1'b1;
        in1   = s1;
        in2   = s2;
        @(posedge clk); #1;
        start = 1'b0;
        in1   = {$urandom, $urandom};
        in2   = {$urandom, $urandom};
        lat   = -1;
        early = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) early = out1 ^ out2;
            if (done) begin
                lat = c;
                break;
            end
            start = (c == pa) || (c == pb);
            if (start) begin
                in1 = ONES;
                in2 = '0;
            end
        end
        start = 1'b0;
        $display("txn in=%h lat=%0d out=%h", s1 ^ s2, lat, out1 ^ out2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (prng_en !== 1'b0) begin errors++; $display("FAIL reset_prng got %b want 0", prng_en); end
        checks++; if ({sbi1, sbi2} !== 8'h00) begin errors++; $display("FAIL reset_sbox_in got %h want 00", {sbi1, sbi2}); end
        checks++; if (out1 !== 64'h0) begin errors++; $display("FAIL reset_out1 got %h want 0", out1); end
        checks++; if (out2 !== 64'h0) begin errors++; $display("FAIL reset_out2 got %h want 0", out2); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat;
        logic [63:0] early;
        run_op(64'h0, 64'h0, -1, -1, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got %0d want 17", lat); end
        checks++; if ((out1 ^ out2) !== ZERO_RES) begin errors++; $display("FAIL zero_result got %h want %h", out1 ^ out2, ZERO_RES); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b want 0", busy); end
    endtask

    task automatic test_masked;
        int lat;
        logic [63:0] early;
        logic [63:0] m;
        m = {$urandom, $urandom};
        prng_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        run_op(PLAIN ^ m, m, -1, -1, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL masked_latency got %0d want 17", lat); end
        checks++; if ((out1 ^ out2) !== PLAIN_RES) begin errors++; $display("FAIL masked_result got %h want %h", out1 ^ out2, PLAIN_RES); end
        @(posedge clk); #1;
        checks++; if (prng_cnt !== 16) begin errors++; $display("FAIL masked_prng_cycles got %0d want 16", prng_cnt); end
        checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL masked_busy_cycles got %0d want 16", busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL masked_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy;
        int lat;
        logic [63:0] early;
        logic [63:0] m;
        m = {$urandom, $urandom};
        done_cnt = 0;
        run_op(PLAIN ^ m, m, 3, 10, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL busy_start_latency got %0d want 17", lat); end
        checks++; if ((out1 ^ out2) !== PLAIN_RES) begin errors++; $display("FAIL busy_start_result got %h want %h", out1 ^ out2, PLAIN_RES); end
        repeat (25) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
        checks++; if ((out1 ^ out2) !== PLAIN_RES) begin errors++; $display("FAIL busy_start_hold got %h want %h", out1 ^ out2, PLAIN_RES); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] early;
        logic [63:0] m;
        m = {$urandom, $urandom};
        done_cnt = 0;
        run_op(PLAIN ^ m, m, -1, -1, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_first_latency got %0d want 17", lat); end
        m = {$urandom, $urandom};
        run_op(ONES ^ m, m, -1, -1, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_second_latency got %0d want 17", lat); end
        checks++; if (early !== PLAIN_RES) begin errors++; $display("FAIL b2b_held_result got %h want %h", early, PLAIN_RES); end
        checks++; if ((out1 ^ out2) !== ONES_RES) begin errors++; $display("FAIL b2b_result got %h want %h", out1 ^ out2, ONES_RES); end
        @(posedge clk); #1;
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [63:0] early;
        logic [63:0] m;
        m = {$urandom, $urandom};
        start = 1'b1;
        in1   = PLAIN ^ m;
        in2   = m;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (prng_en !== 1'b1) begin errors++; $display("FAIL mid_issue_active got %b want 1", prng_en); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
        checks++; if (prng_en !== 1'b0) begin errors++; $display("FAIL mid_rst_prng got %b want 0", prng_en); end
        checks++; if ({sbi1, sbi2} !== 8'h00) begin errors++; $display("FAIL mid_rst_sbox_in got %h want 00", {sbi1, sbi2}); end
        checks++; if ({out1, out2} !== 128'h0) begin errors++; $display("FAIL mid_rst_out got %h want 0", {out1, out2}); end
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d want 0", done_cnt); end
        checks++; if ({out1, out2} !== 128'h0) begin errors++; $display("FAIL mid_rst_discard got %h want 0", {out1, out2}); end
        m = {$urandom, $urandom};
        run_op(PLAIN ^ m, m, -1, -1, lat, early);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mid_rst_fresh_latency got %0d want 17", lat); end
        checks++; if ((out1 ^ out2) !== PLAIN_RES) begin errors++; $display("FAIL mid_rst_fresh_result got %h want %h", out1 ^ out2, PLAIN_RES); end
    endtask

    task automatic test_random_masks;
        int lat;
        logic [63:0] early;
        logic [63:0] m;
        logic [63:0] first_s1;
        logic varied;
        first_s1 = '0;
        varied   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            m = {$urandom, $urandom};
            run_op(PLAIN ^ m, m, -1, -1, lat, early);
            checks++; if (lat !== 17) begin errors++; $display("FAIL rand_latency iter %0d got %0d want 17", i, lat); end
            checks++; if ((out1 ^ out2) !== PLAIN_RES) begin errors++; $display("FAIL rand_result iter %0d got %h want %h", i, out1 ^ out2, PLAIN_RES); end
            if (i == 0) first_s1 = out1;
            else if (out1 !== first_s1) varied = 1'b1;
        end
        @(posedge clk); #1;
        checks++; if (varied !== 1'b1) begin errors++; $display("FAIL rand_share1_varies got %b want 1", varied); end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL idle_sbox_drive got %0d cycles want 0", idle_bad); end
    endtask

    initial begin
        test_reset();
        idle_bad = 0;
        test_zero();
        test_masked();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random_masks();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
